avalon_chained_counter_pio: RTL and testbench

//  Avalon-MM slave holding NUM_CH parallel output fields; generalises the single 7-bit write-only PIO.

---
 rtl/avalon_chained_counter_pio_pkg.sv | 35 +++
 rtl/avalon_chained_counter_pio_if.sv | 16 +
 rtl/avalon_chained_counter_pio_mod_counter_ch.sv | 42 ++++
 rtl/avalon_chained_counter_pio.sv | 107 ++++++++++
 tb/tb_avalon_chained_counter_pio.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/avalon_chained_counter_pio_pkg.sv
// Shared register-map constants and helpers for the chained counter PIO.
//   - Address constants for CTRL and STATUS.
//   - CTRL/STATUS bit positions.
//   - Register-select decode and per-channel modulus helper.
package avalon_chained_counter_pio_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;

  localparam int unsigned CTRL_RUN_BIT    = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned STATUS_WRAP_BIT = 0;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_CTRL,
    SEL_STATUS
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [3:0] addr, input int unsigned num_ch);
    if (addr == ADDR_CTRL)             return SEL_CTRL;
    else if (addr == ADDR_STATUS)      return SEL_STATUS;
    else if (32'(addr) < num_ch)       return SEL_DATA;
    else                               return SEL_NONE;
  endfunction

  // A modulus of 2**width does not fit in its width-bit slice, so it is
  // packed as 0; expand it back here.
  function automatic int unsigned channel_modulus(input int unsigned slice,
                                                  input int unsigned width);
    return (slice == 0) ? (32'd1 << width) : slice;
  endfunction

endpackage

// File: rtl/avalon_chained_counter_pio_if.sv
// Avalon-MM slave bus bundle for the chained counter PIO.
//   address    word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   combinational, zero-extended read data
interface avalon_chained_counter_pio_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_chained_counter_pio_mod_counter_ch.sv
// One modulo counter channel of the chain.
//   clk, reset_n    clock, asynchronous active-low reset
//   load, load_val  software write; values >= MODULUS saturate to MODULUS-1
//   carry_in        advance request from the lower channel (or the tick)
//   value           current channel value
//   carry_out_comb  carry into the next channel; suppressed by a same-cycle load
module mod_counter_ch #(
  parameter int unsigned WIDTH   = 7,
  parameter int unsigned MODULUS = 60
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [31:0]      load_val,
  input  logic             carry_in,
  output logic [WIDTH-1:0] value,
  output logic             carry_out_comb
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] value_q, value_d;
  logic             at_max;

  assign at_max         = (value_q == MAX_VAL);
  assign carry_out_comb = carry_in & at_max & ~load;
  assign value          = value_q;

  always_comb begin
    value_d = value_q;
    if (load)
      value_d = (load_val >= MODULUS) ? MAX_VAL : load_val[WIDTH-1:0];
    else if (carry_in)
      value_d = at_max ? '0 : value_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value_q <= '0;
    else          value_q <= value_d;
  end

endmodule

// File: rtl/avalon_chained_counter_pio.sv
// Avalon-MM PIO holding NUM_CH chained modulo counter fields (sec->min->hour).
//   clk, reset_n  clock, asynchronous active-low reset
//   bus           Avalon-MM slave (DATA[i] at 0..NUM_CH-1, CTRL at 8, STATUS at 9)
//   tick_in       1-cycle advance pulse
//   out_port      all channel values, ch i at [i*DATA_WIDTH +: DATA_WIDTH]
//   irq           STATUS.wrap & CTRL.irq_en
//   carry_out     1-cycle pulse the cycle after the top channel wraps
module avalon_chained_counter_pio
  import avalon_chained_counter_pio_pkg::*;
#(
  parameter int unsigned                       DATA_WIDTH = 7,
  parameter int unsigned                       NUM_CH     = 3,
  parameter logic [NUM_CH*DATA_WIDTH-1:0]      CH_MODULUS = {7'd24, 7'd60, 7'd60}
) (
  input  logic                         clk,
  input  logic                         reset_n,
  avalon_chained_counter_pio_if.slave  bus,
  input  logic                         tick_in,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_port,
  output logic                         irq,
  output logic                         carry_out
);

  logic            wr;
  reg_sel_e        sel;
  logic            run_eff;
  logic [NUM_CH:0] carry;
  logic            run_q, run_d;
  logic            irq_en_q, irq_en_d;
  logic            wrap_q, wrap_d;
  logic            carry_out_q, carry_out_d;
  logic [31:0]     rdata;

  assign wr  = bus.chipselect & ~bus.write_n;
  assign sel = decode_addr(bus.address, NUM_CH);

  // A CTRL write in the same cycle as a tick decides whether that tick counts.
  assign run_eff  = (wr && sel == SEL_CTRL) ? bus.writedata[CTRL_RUN_BIT] : run_q;
  assign carry[0] = run_eff & tick_in;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic load;
    assign load = wr && (sel == SEL_DATA) && (bus.address == 4'(i));

    mod_counter_ch #(
      .WIDTH   (DATA_WIDTH),
      .MODULUS (channel_modulus(32'(CH_MODULUS[i*DATA_WIDTH +: DATA_WIDTH]), DATA_WIDTH))
    ) u_ch (
      .clk            (clk),
      .reset_n        (reset_n),
      .load           (load),
      .load_val       (bus.writedata),
      .carry_in       (carry[i]),
      .value          (out_port[i*DATA_WIDTH +: DATA_WIDTH]),
      .carry_out_comb (carry[i+1])
    );
  end

  always_comb begin
    run_d    = run_q;
    irq_en_d = irq_en_q;
    if (wr && sel == SEL_CTRL) begin
      run_d    = bus.writedata[CTRL_RUN_BIT];
      irq_en_d = bus.writedata[CTRL_IRQ_EN_BIT];
    end
    // Clear first so a wrap in the same cycle keeps the flag set.
    wrap_d = wrap_q;
    if (wr && sel == SEL_STATUS && bus.writedata[STATUS_WRAP_BIT]) wrap_d = 1'b0;
    if (carry[NUM_CH]) wrap_d = 1'b1;
    carry_out_d = carry[NUM_CH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      wrap_q      <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      run_q       <= run_d;
      irq_en_q    <= irq_en_d;
      wrap_q      <= wrap_d;
      carry_out_q <= carry_out_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (sel)
      SEL_DATA: begin
        for (int unsigned i = 0; i < NUM_CH; i++)
          if (bus.address == 4'(i)) rdata = 32'(out_port[i*DATA_WIDTH +: DATA_WIDTH]);
      end
      SEL_CTRL: begin
        rdata[CTRL_RUN_BIT]    = run_q;
        rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      SEL_STATUS: rdata[STATUS_WRAP_BIT] = wrap_q;
      default:    rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign irq          = wrap_q & irq_en_q;
  assign carry_out    = carry_out_q;

endmodule

// File: tb/tb_avalon_chained_counter_pio.sv
module tb_avalon_chained_counter_pio;

  logic clk = 1'b0;
  logic reset_n;
  logic tick_a, tick_b;
  logic [20:0] out_a;
  logic [3:0]  out_b;
  logic irq_a, irq_b, cout_a, cout_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  avalon_chained_counter_pio_if bus_a ();
  avalon_chained_counter_pio_if bus_b ();

  always #5 clk = ~clk;

  avalon_chained_counter_pio dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .tick_in(tick_a),
    .out_port(out_a), .irq(irq_a), .carry_out(cout_a)
  );

  avalon_chained_counter_pio #(
    .DATA_WIDTH (4),
    .NUM_CH     (1),
    .CH_MODULUS (4'd10)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .tick_in(tick_b),
    .out_port(out_b), .irq(irq_b), .carry_out(cout_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hms(input int unsigned h, input int unsigned m, input int unsigned s);
    return {11'd0, 7'(h), 7'(m), 7'(s)};
  endfunction

  // One bus write, optionally with a tick in the same cycle; returns at the
  // falling edge after the committing rising edge.
  task automatic bus_wr(input bit sel, input logic [3:0] a, input logic [31:0] d, input bit tk);
    @(negedge clk);
    if (!sel) begin
      bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0; tick_a = tk;
    end else begin
      bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0; tick_b = tk;
    end
    @(negedge clk);
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; tick_a = 1'b0;
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; tick_b = 1'b0;
  endtask

  task automatic ticks(input bit sel, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      if (!sel) tick_a = 1'b1; else tick_b = 1'b1;
      @(negedge clk);
      tick_a = 1'b0; tick_b = 1'b0;
    end
  endtask

  task automatic rd_chk(input bit sel, input logic [3:0] a, input logic [31:0] exp, input string tag);
    if (!sel) bus_a.address = a; else bus_b.address = a;
    #1;
    check(tag, sel ? bus_b.readdata : bus_a.readdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    tick_a = 1'b0; tick_b = 1'b0;
    bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
    #1;
    check("rst_out_a", 32'(out_a), 32'd0);
    check("rst_irq_a", 32'(irq_a), 32'd0);
    check("rst_cout_a", 32'(cout_a), 32'd0);
    rd_chk(0, 4'd8, 32'd0, "rst_ctrl_a");
    rd_chk(0, 4'd9, 32'd0, "rst_status_a");
    @(negedge clk);
    reset_n = 1'b1;

    // Saturating writes and unmapped addresses, 3-channel instance
    bus_wr(0, 4'd2, 32'd30, 0);
    rd_chk(0, 4'd2, 32'd23, "sat_hour");
    bus_wr(0, 4'd0, 32'd61, 0);
    rd_chk(0, 4'd0, 32'd59, "sat_sec");
    bus_wr(0, 4'd12, 32'h3FF, 0);
    rd_chk(0, 4'd12, 32'd0, "unmapped_rd");
    check("unmapped_wr_out", 32'(out_a), hms(23, 0, 59));
    rd_chk(0, 4'd3, 32'd0, "ch_idx_ge_num");

    // Full wrap 23:59:59 -> 00:00:00
    bus_wr(0, 4'd1, 32'd59, 0);
    bus_wr(0, 4'd8, 32'd3, 0);
    rd_chk(0, 4'd8, 32'd3, "ctrl_rb");
    ticks(0, 1);
    check("wrap_out", 32'(out_a), 32'd0);
    check("wrap_cout_hi", 32'(cout_a), 32'd1);
    check("wrap_irq", 32'(irq_a), 32'd1);
    rd_chk(0, 4'd9, 32'd1, "wrap_status");
    @(negedge clk);
    check("wrap_cout_lo", 32'(cout_a), 32'd0);
    bus_wr(0, 4'd9, 32'd1, 0);
    check("w1c_irq", 32'(irq_a), 32'd0);
    rd_chk(0, 4'd9, 32'd0, "w1c_status");

    // run=0 ignores ticks; run=1 counts with carry into minutes
    bus_wr(0, 4'd0, 32'd58, 0);
    bus_wr(0, 4'd8, 32'd0, 0);
    ticks(0, 5);
    check("stopped_out", 32'(out_a), hms(0, 0, 58));
    bus_wr(0, 4'd8, 32'd1, 0);
    ticks(0, 5);
    check("run5_out", 32'(out_a), hms(0, 1, 3));

    // Write to DATA[1] collides with carry from ch0
    bus_wr(0, 4'd0, 32'd59, 0);
    bus_wr(0, 4'd1, 32'd10, 0);
    bus_wr(0, 4'd2, 32'd5, 0);
    bus_wr(0, 4'd1, 32'd40, 1);
    check("wr_vs_carry", 32'(out_a), hms(5, 40, 0));

    // CTRL write clearing run, same cycle as tick
    bus_wr(0, 4'd8, 32'd0, 1);
    check("stop_with_tick", 32'(out_a), hms(5, 40, 0));

    // STATUS clear in the same cycle as a new wrap: wrap stays set
    bus_wr(0, 4'd0, 32'd59, 0);
    bus_wr(0, 4'd1, 32'd59, 0);
    bus_wr(0, 4'd2, 32'd23, 0);
    bus_wr(0, 4'd8, 32'd1, 0);
    bus_wr(0, 4'd9, 32'd1, 1);
    check("w1c_vs_set_out", 32'(out_a), 32'd0);
    rd_chk(0, 4'd9, 32'd1, "w1c_vs_set_status");

    // Single 4-bit mod-10 channel
    bus_wr(1, 4'd0, 32'd12, 0);
    rd_chk(1, 4'd0, 32'd9, "b_sat");
    bus_wr(1, 4'd12, 32'h3FF, 0);
    rd_chk(1, 4'd12, 32'd0, "b_unmapped_rd");
    check("b_unmapped_out", 32'(out_b), 32'd9);
    rd_chk(1, 4'd1, 32'd0, "b_ch_idx_ge_num");
    bus_wr(1, 4'd8, 32'd3, 0);
    ticks(1, 1);
    check("b_wrap_out", 32'(out_b), 32'd0);
    check("b_cout_hi", 32'(cout_b), 32'd1);
    check("b_irq", 32'(irq_b), 32'd1);
    rd_chk(1, 4'd9, 32'd1, "b_status");
    @(negedge clk);
    check("b_cout_lo", 32'(cout_b), 32'd0);
    bus_wr(1, 4'd9, 32'd1, 0);
    check("b_w1c_irq", 32'(irq_b), 32'd0);
    bus_wr(1, 4'd0, 32'd8, 0);
    bus_wr(1, 4'd8, 32'd0, 0);
    ticks(1, 5);
    check("b_stopped", 32'(out_b), 32'd8);
    bus_wr(1, 4'd8, 32'd1, 0);
    ticks(1, 5);
    check("b_run5", 32'(out_b), 32'd3);
    rd_chk(1, 4'd9, 32'd1, "b_rewrap_status");
    check("b_irq_masked", 32'(irq_b), 32'd0);
    bus_wr(1, 4'h0, 32'h3FF, 0);
    rd_chk(1, 4'd0, 32'd9, "b_zero_ext");

    // Asynchronous reset mid-run, between clock edges
    bus_wr(0, 4'd8, 32'd3, 0);
    bus_wr(0, 4'd0, 32'd17, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_out_a", 32'(out_a), 32'd0);
    check("async_irq_a", 32'(irq_a), 32'd0);
    check("async_out_b", 32'(out_b), 32'd0);
    rd_chk(0, 4'd8, 32'd0, "async_ctrl_a");
    rd_chk(1, 4'd9, 32'd0, "async_status_b");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
